instr_fetch: RTL and testbench

- Instruction fetch stage that sits directly upstream of the R-type decoder.
- Holds the PC and a word-addressed instruction memory, and presents one 32-bit instruction per cycle through a valid/ready handshake.
- Supports stall (backpressure), PC redirect (branch/jump target) and halt on EBREAK.
- A loader write port fills the memory from the bench or boot logic.

---
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage feeding the R-type decoder. Holds the PC and a
//   word-addressed instruction memory and presents one 32-bit instruction
//   per cycle on a valid/ready handshake. Supports backpressure, PC redirect
//   and halt on EBREAK. A loader port fills the memory.
//
//   Optional build macro: FETCH_COUNT_EN adds the fetch_count output, which
//   counts completed transfers.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   imem_we      loader write enable
//   imem_waddr   loader word index
//   imem_wdata   loader write data
//   redirect     load redirect_pc as the next fetch address
//   redirect_pc  redirect target, bits [1:0] ignored
//   out_ready    decoder can accept an instruction
//   out_valid    instruction/pc_out hold a valid fetch
//   instruction  fetched word
//   pc_out       address of the presented instruction
//   halted       EBREAK accepted, fetching stopped
//   fetch_count  (FETCH_COUNT_EN only) completed transfer count
// ---------------------------------------------------------------------------
// state | meaning
// BOOT  | first cycle after reset, performs the initial fetch
// RUN   | normal fetch with handshake, stall and redirect
// HALT  | EBREAK accepted, waiting for redirect or reset
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int         ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       instruction,
    output logic [31:0]       pc_out,
    output logic              halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_n, pc_out_n;
    logic        valid_n, halted_n;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] rpc;
    logic        xfer;

    // Loader write; not reset so memory survives rst.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // Masking (rather than slicing) keeps every redirect_pc bit in use.
    assign rpc  = redirect_pc & ~32'h0000_0003;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pc_out      <= RESET_PC;
            instruction <= 32'h0;
            out_valid   <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pc_out      <= pc_out_n;
            instruction <= instr_n;
            out_valid   <= valid_n;
            halted      <= halted_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        pc_out_n = pc_out;
        instr_n  = instruction;
        valid_n  = out_valid;
        halted_n = halted;
        case (state)
            BOOT: begin
                instr_n  = mem[pc[ADDR_W+1:2]];
                pc_out_n = pc;
                pc_n     = pc + 32'd4;
                valid_n  = 1'b1;
                state_n  = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Any pending output is dropped in favour of the target.
                    instr_n  = mem[rpc[ADDR_W+1:2]];
                    pc_out_n = rpc;
                    pc_n     = rpc + 32'd4;
                    valid_n  = 1'b1;
                end else if (xfer && instruction == EBREAK) begin
                    valid_n  = 1'b0;
                    halted_n = 1'b1;
                    state_n  = HALT;
                end else if (xfer || !out_valid) begin
                    instr_n  = mem[pc[ADDR_W+1:2]];
                    pc_out_n = pc;
                    pc_n     = pc + 32'd4;
                    valid_n  = 1'b1;
                end
            end
            HALT: begin
                valid_n  = 1'b0;
                halted_n = 1'b1;
                if (redirect) begin
                    instr_n  = mem[rpc[ADDR_W+1:2]];
                    pc_out_n = rpc;
                    pc_n     = rpc + 32'd4;
                    valid_n  = 1'b1;
                    halted_n = 1'b0;
                    state_n  = RUN;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
        end else if (xfer) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed self-checking bench for instr_fetch: sequential fetch, stall,
//   redirect, halt/restart, PC/index wrap, asynchronous reset and, when
//   FETCH_COUNT_EN is defined, the transfer counter.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [31:0]       instruction;
    logic [31:0]       pc_out;
    logic              halted;
`ifdef FETCH_COUNT_EN
    logic [31:0]       fetch_count;
`endif

    int tests_run;
    int tests_failed;

    localparam logic [31:0] W0     = 32'h0020_81B3;
    localparam logic [31:0] W1     = 32'h4020_81B3;
    localparam logic [31:0] W2     = 32'h0020_F1B3;
    localparam logic [31:0] W3     = 32'h0020_E1B3;
    localparam logic [31:0] W4     = 32'h0000_0013;
    localparam logic [31:0] W63    = 32'hDEAD_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NEW0   = 32'h1111_1111;

    instr_fetch #(
        .MEM_DEPTH (64),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .instruction (instruction),
        .pc_out      (pc_out),
        .halted      (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = idx;
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        logic [31:0] words [4];
        tests_run    = 0;
        tests_failed = 0;
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;

        rst = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #1 rst = 1'b1;

        for (int i = 0; i < 4; i++) load(ADDR_W'(i), words[i]);
        load(6'd4, W4);
        load(6'd63, W63);

        check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_instr", instruction, 32'd0);
        check_eq("rst_pc",    pc_out, 32'd0);
        check_eq("rst_halt",  {31'b0, halted}, 32'd0);

        // Sequential fetch
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("seq_pc",    pc_out, 32'(4 * i));
            check_eq("seq_instr", instruction, words[i]);
            check_eq("seq_valid", {31'b0, out_valid}, 32'd1);
        end

        // Stall at pc_out=4
        out_ready = 1'b0;
        do_redirect(32'h4);
        check_eq("stall_pc0", pc_out, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc",    pc_out, 32'h4);
            check_eq("stall_instr", instruction, W1);
            check_eq("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        check_eq("unstall_pc",    pc_out, 32'h8);
        check_eq("unstall_instr", instruction, W2);

        // Redirect while stalled at 8, low bits dropped
        out_ready = 1'b0;
        step();
        check_eq("stall8_pc", pc_out, 32'h8);
        do_redirect(32'h0000_0013);
        check_eq("redir_pc",    pc_out, 32'h10);
        check_eq("redir_instr", instruction, W4);
        check_eq("redir_valid", {31'b0, out_valid}, 32'd1);

        // Halt on EBREAK at word 2
        imem_we = 1'b1; imem_waddr = 6'd2; imem_wdata = EBREAK;
        out_ready = 1'b1;
        do_redirect(32'h0);
        imem_we = 1'b0;
        check_eq("h_pc0", pc_out, 32'h0);
        step();
        check_eq("h_pc4", pc_out, 32'h4);
        step();
        check_eq("h_pc8",   pc_out, 32'h8);
        check_eq("h_ebrk",  instruction, EBREAK);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("halt_valid", {31'b0, out_valid}, 32'd0);
            check_eq("halt_flag",  {31'b0, halted}, 32'd1);
        end
        do_redirect(32'h0);
        check_eq("restart_pc",    pc_out, 32'h0);
        check_eq("restart_halt",  {31'b0, halted}, 32'd0);
        check_eq("restart_valid", {31'b0, out_valid}, 32'd1);

        // Index wrap at MEM_DEPTH
        do_redirect(32'h0000_00FC);
        check_eq("wrap_pc0",    pc_out, 32'h0000_00FC);
        check_eq("wrap_instr0", instruction, W63);
        step();
        check_eq("wrap_pc1",    pc_out, 32'h0000_0100);
        check_eq("wrap_instr1", instruction, W0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        step();
        check_eq("pre_rst_pc", pc_out, 32'h0000_0100);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("arst_pc",    pc_out, 32'd0);
        check_eq("arst_instr", instruction, 32'd0);
        check_eq("arst_halt",  {31'b0, halted}, 32'd0);
        load(6'd2, W2);

        // BOOT edge with a concurrent write to the same index returns old word
        @(negedge clk);
        rst = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = NEW0;
        step();
        imem_we = 1'b0;
        check_eq("boot_pc",    pc_out, 32'h0);
        check_eq("boot_instr", instruction, W0);
`ifdef FETCH_COUNT_EN
        check_eq("cnt_zero", fetch_count, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("cnt_stall_pc", pc_out, 32'h0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("cnt_run_pc", pc_out, 32'(4 * i));
        end
        out_ready = 1'b0;
        do_redirect(32'h0);
        check_eq("new0_pc",    pc_out, 32'h0);
        check_eq("new0_instr", instruction, NEW0);
`ifdef FETCH_COUNT_EN
        check_eq("cnt_five", fetch_count, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
